// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan controller.
package seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef struct packed {
        logic [3:0] data;
        logic       en;
        logic       blink;
    } digit_t;

endpackage

// File: rtl/segment.sv
// Hex to common-anode 7-segment decoder; output bits are {g..a}, active-low.
module segment
    import seg_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        // NOTE: default first so every path assigns seg_o and no latch is inferred.
        seg_o = SEG_OFF;
        case (hex_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin scan of an N-digit common-anode display from a double-buffered
// digit store; shadow contents are committed to the active set only at frame boundaries.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG         = 8,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYC    = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [$clog2(NDIG)-1:0] wr_idx,
    input  logic [3:0]              wr_data,
    input  logic                    wr_en,
    input  logic                    wr_blink,
    input  logic                    wr_last,
    output logic [NDIG-1:0]         an,
    output logic [6:0]              seg,
    output logic                    frame_tick
);

    localparam int IW   = $clog2(NDIG);
    localparam int CMAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int FW   = $clog2(BLINK_FRAMES + 1);

    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] DIG_LAST   = IW'(NDIG - 1);
    localparam logic [FW-1:0] FRAME_WRAP = FW'(BLINK_FRAMES);

    state_t          state_q, state_d;
    logic [IW-1:0]   digit_q, digit_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic            pending_q, pending_d;
    logic [NDIG-1:0] an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            frame_tick_q, frame_tick_d;
    logic            boundary;
    logic            wr_fire;
    logic            lit_d;
    logic [6:0]      dec_seg;
    digit_t          next_entry;
    digit_t          shadow_q [NDIG];
    digit_t          active_q [NDIG];

    assign wr_fire  = wr_valid && !pending_q;
    assign wr_ready = ~pending_q;

    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        cnt_d    = cnt_q + 1'b1;
        boundary = 1'b0;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == SCAN_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    if (digit_q == DIG_LAST) begin
                        digit_d  = '0;
                        boundary = 1'b1;
                    end else begin
                        digit_d = digit_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        pending_d     = pending_q;
        if (boundary) begin
            pending_d   = 1'b0;
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (frame_cnt_d == FRAME_WRAP) begin
                frame_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end
        end
        // A last-write landing in the boundary cycle re-arms the next commit.
        if (wr_fire && wr_last) begin
            pending_d = 1'b1;
        end
    end

    // Decode the entry that will be on the pins next cycle, so outputs can be registered.
    assign next_entry = active_q[digit_d];

    segment u_segment (
        .hex_i (next_entry.data),
        .seg_o (dec_seg)
    );

    always_comb begin
        lit_d        = (state_d == DRIVE) && next_entry.en
                       && !(next_entry.blink && blink_phase_q);
        an_d         = '1;
        seg_d        = SEG_OFF;
        if (lit_d) begin
            an_d[digit_d] = 1'b0;
            seg_d         = dec_seg;
        end
        frame_tick_d = (state_d == DRIVE) && (digit_d == DIG_LAST) && (cnt_d == SCAN_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= BLANK;
            digit_q       <= '0;
            cnt_q         <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            pending_q     <= 1'b0;
            an_q          <= '1;
            seg_q         <= SEG_OFF;
            frame_tick_q  <= 1'b0;
            // NOTE: the digit store is reset on purpose so a reset always yields a dark display.
            for (int i = 0; i < NDIG; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            cnt_q         <= cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
            pending_q     <= pending_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            frame_tick_q  <= frame_tick_d;
            if (boundary && pending_q) begin
                active_q <= shadow_q;
            end
            if (wr_fire && (32'(wr_idx) < NDIG)) begin
                shadow_q[wr_idx] <= '{data: wr_data, en: wr_en, blink: wr_blink};
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for an N-digit common-anode 7-segment display. It owns a double-buffered digit store (value, enable, blink per digit) and writes it through a valid/ready port. It shares the single hex segment decoder across all digits round-robin, driving one active-low anode at a time with dead-time between digits. Shadow-to-active commit happens only at frame boundaries, so the display never tears. It sits between the CPU-side display register interface and the board pins.

## Interface
- NDIG, 8, number of digits, 2..16
- SCAN_DIV, 1000, DRIVE cycles per digit slot, >=1
- BLANK_CYC, 4, dead-time cycles before each DRIVE, >=1
- BLINK_FRAMES, 64, frames per blink half-period, >=1
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  store accepts writes
- wr_idx  in  $clog2(NDIG)  target digit
- wr_data  in  4  hex value
- wr_en  in  1  digit enabled; 0 = dark
- wr_blink  in  1  digit blinks
- wr_last  in  1  final write of an update; requests commit
- an  out  NDIG  anode select, active-low one-hot, registered
- seg  out  7  segments {g..a}, active-low, registered
- frame_tick  out  1  one-cycle pulse at each frame boundary

## Operation
- Reset values: an all 1, seg 7'h7F, wr_ready 1, frame_tick 0. State BLANK, digit 0, counters 0, blink_phase 0, commit pending 0. All shadow and active entries are {data 0, en 0, blink 0}.
- Write: wr_valid&&wr_ready writes shadow[wr_idx] at the next edge. If wr_idx>=NDIG, the write is accepted and discarded. wr_valid while wr_ready=0 is ignored.
- Accepted write with wr_last=1 sets pending. wr_ready is 0 from the next cycle until the commit.
- FSM BLANK: an=all 1, seg=7F for BLANK_CYC cycles, then go to DRIVE for the same digit.
- FSM DRIVE: an[digit]=0 and seg=decode(active[digit].data) for SCAN_DIV cycles. Then digit+1 and BLANK. After digit NDIG-1, wrap to digit 0.
- Frame boundary is the DRIVE(NDIG-1)->BLANK(0) transition cycle. In that cycle:
  - frame_tick=1.
  - If pending, active<=shadow (all digits), pending<=0, wr_ready<=1.
  - The frame counter advances. On reaching BLINK_FRAMES it clears and blink_phase toggles.
- Dark digit (en=0), or blink=1 with blink_phase=1: during DRIVE, an stays all 1 and seg=7F. The slot timing is unchanged.
- A write accepted in the frame-boundary cycle lands in shadow but is not part of the current commit. If it has wr_last=1, it sets pending again.

## Timing
- Frame = NDIG*(BLANK_CYC+SCAN_DIV) cycles. The first DRIVE after reset starts at cycle BLANK_CYC.
- Outputs are registered. They reflect the FSM state of the previous cycle's decision and have no combinational path from inputs.
- Write-to-shadow latency is 1 cycle. Commit-to-pins latency is the rest of the current frame plus BLANK_CYC.
- Never more than one anode is low. Every digit change passes through at least BLANK_CYC all-high cycles.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous). An uncommitted shadow is lost.
- Counters are sized $clog2(max+1) and must not overflow at the parameter maxima.

## Structure
- Package seg_pkg holds:
  - the state enum {BLANK, DRIVE}
  - SEG_OFF = 7'h7F
  - the digit entry struct {data[3:0], en, blink}
- Instantiates the existing 4-bit hex decoder `segment` once, on the active entry of the next digit. It is the only sub-module.

## Test plan
All scenarios use NDIG=4, SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.
- Reset, no writes -> an=4'hF and seg=7F for 3 frames; frame_tick every 20 cycles; wr_ready=1.
- Write idx0..3 = 1,2,3,4, en=1, last on idx3 -> wr_ready low until boundary. Next frame shows:
  - an=1110, seg=7'b1111001 for 4 cycles
  - blank for 1 cycle
  - an=1101, seg=7'b0100100, and so on
- Writes without wr_last -> pins unchanged across 3 frames. A later wr_last commits all digits together.
- idx2 blink=1 -> digit 2 is dark in frames 2-3, lit in frames 4-5, dark in frames 6-7. Other digits are steady.
- wr_valid held while wr_ready=0 with data 0xF -> shadow is not modified. Assert rst in mid-DRIVE -> an=F and seg=7F in the same cycle, and the display stays dark afterwards.
- Every cycle, check an is one-hot-low or all-high. Check at least 1 all-high cycle between different low anodes.
